uart_rx_msg_reg: RTL and testbench

- Receive-side counterpart of the transmit path: deserialises an 8N1 UART frame from rx_serial and latches the byte into a holding register.
- The holding register presents the byte to game logic with a valid/ack handshake.
- Flags framing errors (bad stop bit) and overruns (new byte while previous unconsumed).
- Sits between the radio/serial input pin and the hangman game controller.

---
 rtl/uart_rx_msg_reg.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_msg_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_msg_reg.sv
// uart_rx_msg_reg
//   8N1 UART receiver with a single-byte holding register. Deserialises
//   rx_serial (LSB first) and presents each good byte to the game controller
//   through a valid/ack handshake. Bad stop bits and unconsumed-byte overruns
//   are flagged with one-cycle pulses.
//
// Ports
//   clk         system clock
//   nRst        asynchronous active-low reset
//   rx_serial   asynchronous serial line, idle high
//   rx_ack      consumer acknowledge; clears rx_valid
//   rx_byte     last accepted byte
//   rx_valid    rx_byte holds an unconsumed byte
//   rx_busy     receiver is inside a frame (FSM not idle)
//   framing_err one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: byte completed while previous one unconsumed

module uart_rx_msg_reg #(
    parameter int unsigned CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       framing_err,
    output logic       overrun
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StData  = 2'd2;
    localparam logic [1:0] StStop  = 2'd3;

    // Input synchroniser
    logic rx_meta_q, rx_s_q;

    // Receiver state
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    // Line has been seen high since the last frame ended; a held-low line
    // (break) must go high again before a new start bit is recognised.
    logic             seen_high_q, seen_high_d;

    // Holding register and flags
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_busy_q, rx_busy_d;
    logic       framing_err_q, framing_err_d;
    logic       overrun_q, overrun_d;

    // Strobes from the FSM at the mid-stop sample
    logic accept;
    logic frame_bad;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_serial;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        seen_high_d = seen_high_q;
        accept      = 1'b0;
        frame_bad   = 1'b0;

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_cnt_d = '0;
                if (rx_s_q) begin
                    seen_high_d = 1'b1;
                end else if (seen_high_q) begin
                    state_d     = StStart;
                    seen_high_d = 1'b0;
                end
            end

            StStart: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = StData;
                    end else begin
                        // Start glitch: line already back high, so it counts as seen high.
                        state_d     = StIdle;
                        seen_high_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            StData: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = StStop;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            StStop: begin
                if (clk_cnt_q == BIT_LAST) begin
                    // Leave at mid stop bit so an immediately following start edge is caught.
                    clk_cnt_d = '0;
                    state_d   = StIdle;
                    if (rx_s_q) begin
                        accept      = 1'b1;
                        seen_high_d = 1'b1;
                    end else begin
                        frame_bad   = 1'b1;
                        seen_high_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        rx_byte_d     = rx_byte_q;
        rx_valid_d    = rx_valid_q;
        framing_err_d = frame_bad;
        overrun_d     = 1'b0;
        rx_busy_d     = (state_d != StIdle);

        if (accept) begin
            // An ack on the accept cycle frees the register for the new byte.
            if (!rx_valid_q || rx_ack) begin
                rx_byte_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q       <= StIdle;
            clk_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            seen_high_q   <= 1'b0;
            rx_byte_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_busy_q     <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            seen_high_q   <= seen_high_d;
            rx_byte_q     <= rx_byte_d;
            rx_valid_q    <= rx_valid_d;
            rx_busy_q     <= rx_busy_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

    assign rx_byte     = rx_byte_q;
    assign rx_valid    = rx_valid_q;
    assign rx_busy     = rx_busy_q;
    assign framing_err = framing_err_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_msg_reg.sv
// Self-checking bench for uart_rx_msg_reg with CLKS_PER_BIT=4. Inputs are
// driven and outputs sampled on the falling clock edge.

module tb_uart_rx_msg_reg;

    localparam int unsigned CPB = 4;
    // Falling edge of start bit to rx_valid visible: 2 + CPB/2 + 9*CPB + 1
    localparam int unsigned LAT = 2 + CPB / 2 + 9 * CPB + 1;

    logic       clk = 1'b0;
    logic       nRst = 1'b0;
    logic       rx_serial = 1'b1;
    logic       ack_mon = 1'b0;
    logic       ack_man = 1'b0;
    logic       rx_ack;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_busy;
    logic       framing_err;
    logic       overrun;

    int n_checks = 0;
    int n_pass = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    bit auto_ack = 1'b0;
    logic [7:0] exp_q[$];

    assign rx_ack = ack_mon | ack_man;

    uart_rx_msg_reg #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .rx_serial  (rx_serial),
        .rx_ack     (rx_ack),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_busy    (rx_busy),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and scoreboard consumer (acks each delivered byte once).
    always @(negedge clk) begin
        if (framing_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (ack_mon) begin
            ack_mon = 1'b0;
        end else if (auto_ack && rx_valid) begin
            check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("sb_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
            ack_mon = 1'b1;
        end
    end

    // Called on a falling edge; returns on the falling edge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic line_after);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_serial = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_serial = line_after;
    endtask

    task automatic send_exp(input logic [7:0] b);
        exp_q.push_back(b);
        send_frame(b, 1'b1, 1'b1);
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!rx_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic pulse_ack();
        ack_man = 1'b1;
        @(negedge clk);
        ack_man = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_byte"}, 32'(rx_byte), 32'h00);
        check_eq({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check_eq({tag, "_busy"}, 32'(rx_busy), 32'd0);
        check_eq({tag, "_ferr"}, 32'(framing_err), 32'd0);
        check_eq({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int lat;
        int f0;
        int o0;
        bit saw_busy;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        nRst = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame 0x41, latency, ack.
        fork
            send_frame(8'h41, 1'b1, 1'b1);
            wait_valid(lat);
        join
        check_eq("lat", 32'(lat), 32'(LAT));
        check_eq("single_byte", 32'(rx_byte), 32'h41);
        check_eq("single_valid", 32'(rx_valid), 32'd1);
        pulse_ack();
        check_eq("ack_valid", 32'(rx_valid), 32'd0);
        check_eq("ack_byte", 32'(rx_byte), 32'h41);

        // Start glitch shorter than half a bit.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        saw_busy = 1'b0;
        rx_serial = 1'b0;
        repeat (CPB / 2 - 1) @(negedge clk);
        rx_serial = 1'b1;
        for (int i = 0; i < 4 * CPB; i++) begin
            @(negedge clk);
            if (rx_busy) saw_busy = 1'b1;
        end
        check_eq("glitch_seen", 32'(saw_busy), 32'd1);
        check_eq("glitch_busy", 32'(rx_busy), 32'd0);
        check_eq("glitch_valid", 32'(rx_valid), 32'd0);
        check_eq("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_eq("glitch_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Framing error on 0x5A, line then held low (break).
        f0 = ferr_cnt;
        send_frame(8'h5A, 1'b0, 1'b0);
        repeat (30 * CPB) @(negedge clk);
        check_eq("ferr_pulses", 32'(ferr_cnt - f0), 32'd1);
        check_eq("ferr_valid", 32'(rx_valid), 32'd0);
        check_eq("ferr_byte", 32'(rx_byte), 32'h41);
        check_eq("break_busy", 32'(rx_busy), 32'd0);
        rx_serial = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_eq("break_release_busy", 32'(rx_busy), 32'd0);

        // Overrun: 0x48 unconsumed, then 0x4D.
        o0 = ovr_cnt;
        send_frame(8'h48, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("ovr_first_byte", 32'(rx_byte), 32'h48);
        send_frame(8'h4D, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_eq("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        check_eq("ovr_byte", 32'(rx_byte), 32'h48);
        check_eq("ovr_valid", 32'(rx_valid), 32'd1);
        pulse_ack();
        check_eq("ovr_ack_valid", 32'(rx_valid), 32'd0);

        // Same again but ack lands on the accept cycle of 0x4D.
        send_frame(8'h48, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        o0 = ovr_cnt;
        fork
            send_frame(8'h4D, 1'b1, 1'b1);
            begin
                repeat (LAT - 1) @(negedge clk);
                ack_man = 1'b1;
                @(negedge clk);
                ack_man = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check_eq("ackacc_ovr", 32'(ovr_cnt - o0), 32'd0);
        check_eq("ackacc_byte", 32'(rx_byte), 32'h4D);
        check_eq("ackacc_valid", 32'(rx_valid), 32'd1);
        pulse_ack();

        // Back-to-back frames through the scoreboard.
        f0 = ferr_cnt;
        o0 = ovr_cnt;
        auto_ack = 1'b1;
        send_exp(8'h00);
        send_exp(8'hFF);
        send_exp(8'hA5);
        repeat (3 * CPB) @(negedge clk);
        check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);
        check_eq("b2b_ferr", 32'(ferr_cnt - f0), 32'd0);
        check_eq("b2b_ovr", 32'(ovr_cnt - o0), 32'd0);
        check_eq("b2b_last_byte", 32'(rx_byte), 32'hA5);
        auto_ack = 1'b0;

        // Reset in the middle of a frame while the line keeps toggling.
        fork
            send_frame(8'hC3, 1'b1, 1'b1);
            begin
                repeat (15) @(negedge clk);
                nRst = 1'b0;
                repeat (3) @(negedge clk);
                check_reset_outputs("midrst");
            end
        join
        repeat (2) @(negedge clk);
        nRst = 1'b1;
        repeat (10) @(negedge clk);
        auto_ack = 1'b1;
        send_exp(8'h41);
        repeat (3 * CPB) @(negedge clk);
        check_eq("post_rst_drained", 32'(exp_q.size()), 32'd0);
        check_eq("post_rst_byte", 32'(rx_byte), 32'h41);
        auto_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
